// File: rtl/tti_tx_word_unpacker.sv
// tti_tx_word_unpacker: unpacks TX queue words into little-endian bytes for one transfer, draining the rest on flush
//   clk_i/rst_i             clock, async active-high reset
//   xfer_len_*              per-transfer byte length handshake (accepted only when idle)
//   word_*                  TX queue words in, word_ready_o is the pop
//   byte_*                  bytes out to the descriptor stage, byte_last_o on the final byte
//   flush_i                 abort current transfer; owed words are drained from the queue
//   holding_o / busy_o      a word is latched / not idle
module tti_tx_word_unpacker #(
  parameter int WordWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 xfer_len_valid_i,
  output logic                 xfer_len_ready_o,
  input  logic [15:0]          xfer_len_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [WordWidth-1:0] word_data_i,
  output logic                 byte_valid_o,
  input  logic                 byte_ready_i,
  output logic [7:0]           byte_data_o,
  output logic                 byte_last_o,
  input  logic                 flush_i,
  output logic                 holding_o,
  output logic                 busy_o
);
  localparam int BPW = WordWidth / 8;
  localparam int IW = $clog2(BPW);
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;
  state_t               state_q, state_d;
  logic [WordWidth-1:0] word_q, word_d;
  logic [IW-1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [14:0]          words_left_q, words_left_d;
  logic [16:0]          span, owed;
  logic                 refill;
  assign xfer_len_ready_o = state_q == IDLE;
  assign byte_valid_o     = state_q == SEND && !flush_i;
  assign byte_data_o      = word_q[{byte_idx_q, 3'b000} +: 8];
  assign byte_last_o      = byte_valid_o && remaining_q == 16'd1;
  assign holding_o        = state_q == SEND;
  assign busy_o           = state_q != IDLE;
  // pop the next word in the same cycle the last byte of the current one leaves
  assign refill           = byte_valid_o && byte_ready_i && remaining_q != 16'd1 && byte_idx_q == LAST_IDX;
  assign word_ready_o     = (state_q == LOAD && !flush_i) || state_q == DRAIN || refill;
  // bytes still owed beyond the word currently latched (all of them when none is latched)
  always_comb begin
    span = 17'(BPW) - 17'(byte_idx_q);
    owed = (state_q == LOAD) ? {1'b0, remaining_q}
         : ({1'b0, remaining_q} > span) ? {1'b0, remaining_q} - span : 17'd0;
  end
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    remaining_d  = remaining_q;
    words_left_d = words_left_q;
    unique case (state_q)
      IDLE: if (xfer_len_valid_i && xfer_len_i != 16'd0) begin
        remaining_d = xfer_len_i;
        state_d     = LOAD;
      end
      LOAD, SEND: if (flush_i) begin
        words_left_d = 15'((owed + 17'(BPW - 1)) >> IW);
        state_d      = (words_left_d != 15'd0) ? DRAIN : IDLE;
      end else if (state_q == LOAD) begin
        if (word_valid_i) begin
          word_d     = word_data_i;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end else if (byte_ready_i) begin
        remaining_d = remaining_q - 16'd1;
        byte_idx_d  = byte_idx_q + IW'(1);
        if (remaining_q == 16'd1) state_d = IDLE;
        else if (byte_idx_q == LAST_IDX) begin
          if (word_valid_i) begin
            word_d     = word_data_i;
            byte_idx_d = '0;
          end else state_d = LOAD;
        end
      end
      DRAIN: if (word_valid_i) begin
        words_left_d = words_left_q - 15'd1;
        if (words_left_q == 15'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      word_q       <= '0;
      byte_idx_q   <= '0;
      remaining_q  <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      remaining_q  <= remaining_d;
      words_left_q <= words_left_d;
    end
  end
endmodule

// File: tb/tb_tti_tx_word_unpacker.sv
// tb_tti_tx_word_unpacker: table-driven, hand-written and randomized checks of the TX word unpacker
module tb_tti_tx_word_unpacker;
  localparam int W = 32;
  localparam int BPW = W / 8;
  logic         clk_i = 1'b0, rst_i = 1'b1;
  logic         xfer_len_valid_i = 1'b0, xfer_len_ready_o;
  logic [15:0]  xfer_len_i = '0;
  logic         word_valid_i = 1'b0, word_ready_o;
  logic [W-1:0] word_data_i = '0;
  logic         byte_valid_o, byte_ready_i = 1'b0, byte_last_o;
  logic [7:0]   byte_data_o;
  logic         flush_i = 1'b0, holding_o, busy_o;
  always #5 clk_i = ~clk_i;
  tti_tx_word_unpacker #(.WordWidth(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .xfer_len_valid_i(xfer_len_valid_i), .xfer_len_ready_o(xfer_len_ready_o), .xfer_len_i(xfer_len_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_data_i(word_data_i),
    .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i), .byte_data_o(byte_data_o),
    .byte_last_o(byte_last_o), .flush_i(flush_i), .holding_o(holding_o), .busy_o(busy_o)
  );
  typedef struct {
    int len, stall_at, stall_n, flush_after;
    int exp_got, exp_words, exp_vcyc, exp_span, exp_nlast, exp_lat;
    logic [7:0] exp_last;
  } vec_t;
  vec_t         vecs [6];
  logic [W-1:0] feed [$];
  int           n_cmp = 0, n_err = 0;
  int           got, wpop, vcyc, first_v, first_pop, last_hs, nlast;
  logic [7:0]   last_byte;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input int j);
    logic [W-1:0] w;
    w = (j / BPW < feed.size()) ? feed[j / BPW] : '0;
    return w[8 * (j % BPW) +: 8];
  endfunction
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_len_ready"}, xfer_len_ready_o, 1);
    chk({tag, "_word_ready"}, word_ready_o, 0);
    chk({tag, "_byte_valid"}, byte_valid_o, 0);
    chk({tag, "_byte_data"}, byte_data_o, 0);
    chk({tag, "_byte_last"}, byte_last_o, 0);
    chk({tag, "_holding"}, holding_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask
  // one transfer: bytes must be the first len bytes of feed (little-endian), and the transfer
  // must consume ceil(len/BPW) words in total whether or not it was flushed
  task automatic run_xfer(input int len, input bit rnd, input int stall_at, input int stall_n, input int flush_after);
    int cyc = 0, wi = 0, t = 0, stall_left = stall_n;
    bit flushed = 0, hold = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    got = 0; vcyc = 0; first_v = -1; first_pop = -1; last_hs = -1; nlast = 0; last_byte = '0;
    @(posedge clk_i); #1;
    xfer_len_valid_i = 1'b1;
    xfer_len_i = 16'(len);
    @(negedge clk_i);
    while (!xfer_len_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    chk("len_accept", xfer_len_ready_o, 1);
    @(posedge clk_i); #1;
    xfer_len_valid_i = 1'b0;
    while (busy_o && cyc < 2000) begin
      word_valid_i = (wi < feed.size()) && (!rnd || $urandom_range(0, 3) != 0);
      word_data_i = (wi < feed.size()) ? feed[wi] : '0;
      byte_ready_i = rnd ? ($urandom_range(0, 2) != 0) : !(got == stall_at && stall_left > 0);
      flush_i = !flushed && got == flush_after;
      @(negedge clk_i);
      if (flush_i) begin
        chk("flush_masks_valid", byte_valid_o, 0);
        flushed = 1;
      end else if (hold) begin
        chk("hold_valid", byte_valid_o, 1);
        chk("hold_data", byte_data_o, pd);
        chk("hold_last", byte_last_o, pl);
      end
      if (byte_valid_o) begin
        vcyc++;
        if (first_v < 0) first_v = cyc;
      end
      if (byte_valid_o && byte_ready_i) begin
        chk("byte_data", byte_data_o, exp_byte(got));
        chk("byte_last", byte_last_o, got == len - 1);
        chk("no_byte_after_flush", flushed, 0);
        if (byte_last_o) nlast++;
        last_byte = byte_data_o;
        last_hs = cyc;
        got++;
      end
      if (word_valid_i && word_ready_o) begin
        if (first_pop < 0) first_pop = cyc;
        wi++;
      end
      if (byte_valid_o && !byte_ready_i && stall_left > 0) stall_left--;
      hold = byte_valid_o && !byte_ready_i;
      pd = byte_data_o;
      pl = byte_last_o;
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("xfer_done_in_budget", busy_o, 0);
    word_valid_i = 1'b0;
    byte_ready_i = 1'b0;
    flush_i = 1'b0;
    wpop = wi;
    chk("words_popped", wi, (len + BPW - 1) / BPW);
    if (!flushed) chk("bytes_sent", got, len);
  endtask
  initial begin
    int t, len, fa;
    #2 chk_reset_outs("reset");
    #20;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    // directed table
    vecs[0] = '{4, -1, 0, -1, 4, 1, 4, 4, 1, 1, 8'h44};
    vecs[1] = '{6, -1, 0, -1, 6, 2, 6, 6, 1, 1, 8'h66};
    vecs[2] = '{8, -1, 0, -1, 8, 2, 8, 8, 1, 1, 8'h88};
    vecs[3] = '{4, 1, 3, -1, 4, 1, 7, 7, 1, 1, 8'h44};
    vecs[4] = '{12, -1, 0, 2, 2, 3, 2, 2, 0, 1, 8'h22};
    vecs[5] = '{0, -1, 0, -1, 0, 0, 0, 0, 0, 0, 8'h00};
    feed = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].len, 0, vecs[i].stall_at, vecs[i].stall_n, vecs[i].flush_after);
      chk($sformatf("v%0d_bytes", i), got, vecs[i].exp_got);
      chk($sformatf("v%0d_words", i), wpop, vecs[i].exp_words);
      chk($sformatf("v%0d_valid_cycles", i), vcyc, vecs[i].exp_vcyc);
      chk($sformatf("v%0d_span", i), (got > 0) ? last_hs - first_v + 1 : 0, vecs[i].exp_span);
      chk($sformatf("v%0d_nlast", i), nlast, vecs[i].exp_nlast);
      chk($sformatf("v%0d_latency", i), (first_v >= 0 && first_pop >= 0) ? first_v - first_pop : 0, vecs[i].exp_lat);
      chk($sformatf("v%0d_last_byte", i), last_byte, vecs[i].exp_last);
    end
    // flush in IDLE is ignored, flush in LOAD blocks the pop and drains, flush in DRAIN is ignored
    @(posedge clk_i); #1;
    flush_i = 1'b1; xfer_len_valid_i = 1'b1; xfer_len_i = 16'd4; word_valid_i = 1'b1; word_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("idle_flush_len_ready", xfer_len_ready_o, 1);
    @(posedge clk_i); #1;
    xfer_len_valid_i = 1'b0;
    @(negedge clk_i);
    chk("load_flush_blocks_pop", word_ready_o, 0);
    chk("load_flush_busy", busy_o, 1);
    @(posedge clk_i); #1;
    flush_i = 1'b0; word_valid_i = 1'b0;
    @(negedge clk_i);
    chk("drain_ready", word_ready_o, 1);
    chk("drain_no_byte", byte_valid_o, 0);
    chk("drain_not_holding", holding_o, 0);
    @(posedge clk_i); #1;
    word_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    word_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("drain_done", busy_o, 0);
    // reset in the middle of SEND
    @(posedge clk_i); #1;
    xfer_len_valid_i = 1'b1; xfer_len_i = 16'd8; word_valid_i = 1'b1; word_data_i = 32'h44332211; byte_ready_i = 1'b0;
    @(posedge clk_i); #1;
    xfer_len_valid_i = 1'b0;
    t = 0;
    @(negedge clk_i);
    while (!byte_valid_o && t < 10) begin
      @(negedge clk_i);
      t++;
    end
    chk("midsend_valid", byte_valid_o, 1);
    chk("midsend_data", byte_data_o, 8'h11);
    chk("midsend_holding", holding_o, 1);
    #1 rst_i = 1'b1;
    #1 chk_reset_outs("midsend_rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0; word_valid_i = 1'b0;
    @(negedge clk_i);
    chk_reset_outs("after_rst");
    // randomized transfers against the reference rules
    repeat (150) begin
      len = $urandom_range(0, 40);
      feed.delete();
      for (int k = 0; k < (len + BPW - 1) / BPW + 1; k++) feed.push_back($urandom);
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_xfer(len, 1, -1, 0, fa);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
